seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the multi-digit seven-segment display. Holds a double-buffered bank of 4-bit hex digits and steps through the digits one slot at a time. For each slot it drives `DIGIT_DATA` into the hex-to-segment decoder and one-hot `DIGIT_EN` to the digit enables. An anti-ghosting gap, leading-zero suppression and tear-free frame commits are built in.

---
 rtl/seg_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed seven-segment display.
// It keeps a shadow bank and an active bank of hex digits and lights one digit per slot.
// Each slot opens with a dark gap to prevent ghosting.
// Leading zeros can be blanked.
// A commit copies the shadow bank into the active bank only at the end of a frame.
//
// state | meaning
// ------+---------------------------------------------------------
// GAP   | first GAP_CYCLES of a slot (and the OFF condition), dark
// SHOW  | rest of the slot, current digit lit unless suppressed
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES  = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  commit,
  input  logic                  lz_suppress,
  output logic [3:0]            digit_data,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_done,
  output logic                  commit_pend
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {GAP = 1'b0, SHOW = 1'b1} state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [3:0]            shadow   [NUM_DIGITS];
  logic [3:0]            shadow_n [NUM_DIGITS];
  logic [3:0]            active   [NUM_DIGITS];
  logic [3:0]            active_n [NUM_DIGITS];
  logic                  copy;
  logic                  commit_pend_n;
  logic                  frame_done_n;
  logic [3:0]            digit_data_n;
  logic [NUM_DIGITS-1:0] digit_en_n;
  logic                  zero_run;
  logic                  suppress;

  // Next scan position, bank contents and outputs. The outputs are registered
  // from the next-cycle position so they line up with cnt/idx of their cycle.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    idx_n         = idx;
    shadow_n      = shadow;
    active_n      = active;
    copy          = 1'b0;
    commit_pend_n = commit_pend;
    zero_run      = 1'b1;
    suppress      = 1'b0;
    digit_en_n    = '0;

    if (!en) begin
      state_n = GAP;
      cnt_n   = '0;
      idx_n   = '0;
    end else if (cnt == CNT_LAST) begin
      state_n = GAP;
      cnt_n   = '0;
      idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt_n = cnt + 1'b1;
      if (state == GAP && cnt == GAP_LAST) state_n = SHOW;
    end

    // Out-of-range addresses do not match any slot, so those writes are dropped.
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (wr_en && wr_addr == 3'(i)) shadow_n[i] = wr_data;
    end

    // A commit in the copy cycle is absorbed. The copy takes the post-write
    // shadow, so a same-cycle write is forwarded.
    copy          = (commit_pend | commit) & (frame_done | ~en);
    commit_pend_n = ~copy & (commit_pend | commit);
    if (copy) active_n = shadow_n;

    // zero_run is true when this digit and every more significant digit are zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (active_n[i] == 4'h0);
      if (idx_n == IDX_W'(i)) suppress = zero_run;
    end
    if (!lz_suppress || idx_n == '0) suppress = 1'b0;

    if (state_n == SHOW && !suppress) digit_en_n[idx_n] = 1'b1;
    digit_data_n = active_n[idx_n];
    frame_done_n = (cnt_n == CNT_LAST) && (idx_n == IDX_LAST);
  end

  // State, counters, banks and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= GAP;
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '{default: 4'h0};
      active      <= '{default: 4'h0};
      commit_pend <= 1'b0;
      frame_done  <= 1'b0;
      digit_data  <= 4'h0;
      digit_en    <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shadow      <= shadow_n;
      active      <= active_n;
      commit_pend <= commit_pend_n;
      frame_done  <= frame_done_n;
      digit_data  <= digit_data_n;
      digit_en    <= digit_en_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with 4 digits, 8-cycle slots and a 2-cycle gap.
// The reference model tracks the position in the frame as a single number and
// derives the slot and the phase from it arithmetically.
module tb_seg_scan_ctrl;
  localparam int N     = 4;
  localparam int RD    = 8;
  localparam int GAP   = 2;
  localparam int FRAME = N * RD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       commit;
  logic       lz;
  logic [3:0] digit_data;
  logic [N-1:0] digit_en;
  logic       frame_done;
  logic       commit_pend;

  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .lz_suppress(lz),
    .digit_data(digit_data), .digit_en(digit_en), .frame_done(frame_done),
    .commit_pend(commit_pend)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_pos;
  logic [3:0] m_sh  [N];
  logic [3:0] m_act [N];
  bit         m_pend;
  logic [3:0] e_en, e_data;
  logic       e_fd;

  typedef struct {
    logic       en, wr_en;
    logic [2:0] addr;
    logic [3:0] data;
    logic       commit, lz;
    logic [3:0] x_en, x_data;
    logic       x_fd, x_pend;
  } vec_t;
  vec_t tbl [10];

  function automatic vec_t mk(logic e, logic w, logic [2:0] a, logic [3:0] d, logic c,
                              logic l, logic [3:0] xe, logic [3:0] xd, logic xf, logic xp);
    vec_t v;
    v.en = e; v.wr_en = w; v.addr = a; v.data = d; v.commit = c; v.lz = l;
    v.x_en = xe; v.x_data = xd; v.x_fd = xf; v.x_pend = xp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pos = 0;
    for (int i = 0; i < N; i++) begin
      m_sh[i]  = 4'h0;
      m_act[i] = 4'h0;
    end
    m_pend = 1'b0;
    e_en = 4'h0; e_data = 4'h0; e_fd = 1'b0;
  endfunction

  function automatic void model_step();
    bit copy;
    bit lit;
    bit all_zero;
    int slot, ph;
    copy = (m_pend || commit) && (m_pos == FRAME - 1 || !en);
    if (wr_en && int'(wr_addr) < N) m_sh[wr_addr] = wr_data;
    if (copy) m_act = m_sh;
    m_pend = copy ? 1'b0 : (m_pend || commit);
    m_pos  = en ? (m_pos + 1) % FRAME : 0;
    slot = m_pos / RD;
    ph   = m_pos % RD;
    lit  = (ph >= GAP);
    if (lz && slot != 0) begin
      all_zero = 1'b1;
      for (int j = slot; j < N; j++) if (m_act[j] != 4'h0) all_zero = 1'b0;
      if (all_zero) lit = 1'b0;
    end
    e_en   = lit ? 4'(1 << slot) : 4'h0;
    e_data = m_act[slot];
    e_fd   = (m_pos == FRAME - 1);
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("digit_en", 32'(digit_en), 32'(e_en));
    chk("digit_data", 32'(digit_data), 32'(e_data));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("commit_pend", 32'(commit_pend), 32'(m_pend));
  endtask

  task automatic idle();
    wr_en = 1'b0; commit = 1'b0; wr_addr = 3'd0; wr_data = 4'h0;
  endtask

  task automatic run_until(input int target);
    int n;
    n = 0;
    while (m_pos != target && n < 2 * FRAME) begin
      cycle();
      n++;
    end
    if (m_pos != target) begin
      checks++; errors++;
      $display("FAIL run_until: position %0d not reached", target);
    end
  endtask

  task automatic write(input logic [2:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
    idle();
  endtask

  // Load the active bank with the scan stopped, then scan one full frame
  // and count the lit cycles of each digit.
  task automatic lz_frame(input logic [15:0] vals, input logic [3:0] lit_mask);
    int on [N];
    en = 1'b0; lz = 1'b1;
    for (int k = 0; k < N; k++) write(3'(k), vals[k*4 +: 4]);
    commit = 1'b1;
    cycle();
    idle();
    en = 1'b1;
    for (int k = 0; k < N; k++) on[k] = 0;
    for (int c = 0; c < FRAME; c++) begin
      cycle();
      for (int k = 0; k < N; k++) on[k] += int'(digit_en[k]);
    end
    for (int k = 0; k < N; k++)
      chk($sformatf("lz_on_%0d", k), 32'(on[k]), lit_mask[k] ? 32'(RD - GAP) : 32'd0);
  endtask

  initial begin
    logic [3:0] scan_vals [N];
    int fd_cnt, fd_first, fd_second;
    scan_vals = '{4'h1, 4'h2, 4'h3, 4'h4};

    rst_n = 1'b0; en = 1'b0; lz = 1'b0;
    idle();
    model_reset();
    #1;
    chk("rst_digit_en", 32'(digit_en), 32'd0);
    chk("rst_digit_data", 32'(digit_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_commit_pend", 32'(commit_pend), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed vectors: load shadow while stopped, commit, start scanning.
    tbl[0] = mk(0, 1, 3'd0, 4'h1, 0, 0, 4'h0, 4'h0, 0, 0);
    tbl[1] = mk(0, 1, 3'd1, 4'h2, 0, 0, 4'h0, 4'h0, 0, 0);
    tbl[2] = mk(0, 1, 3'd2, 4'h3, 0, 0, 4'h0, 4'h0, 0, 0);
    tbl[3] = mk(0, 1, 3'd3, 4'h4, 0, 0, 4'h0, 4'h0, 0, 0);
    tbl[4] = mk(0, 1, 3'd5, 4'hF, 0, 0, 4'h0, 4'h0, 0, 0);
    tbl[5] = mk(0, 0, 3'd0, 4'h0, 1, 0, 4'h0, 4'h1, 0, 0);
    tbl[6] = mk(1, 0, 3'd0, 4'h0, 0, 0, 4'h0, 4'h1, 0, 0);
    tbl[7] = mk(1, 0, 3'd0, 4'h0, 0, 0, 4'h1, 4'h1, 0, 0);
    tbl[8] = mk(1, 1, 3'd7, 4'h0, 0, 0, 4'h1, 4'h1, 0, 0);
    tbl[9] = mk(1, 0, 3'd0, 4'h0, 1, 0, 4'h1, 4'h1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      en = tbl[i].en; wr_en = tbl[i].wr_en; wr_addr = tbl[i].addr;
      wr_data = tbl[i].data; commit = tbl[i].commit; lz = tbl[i].lz;
      cycle();
      chk($sformatf("vec%0d_en", i), 32'(digit_en), 32'(tbl[i].x_en));
      chk($sformatf("vec%0d_data", i), 32'(digit_data), 32'(tbl[i].x_data));
      chk($sformatf("vec%0d_fd", i), 32'(frame_done), 32'(tbl[i].x_fd));
      chk($sformatf("vec%0d_pend", i), 32'(commit_pend), 32'(tbl[i].x_pend));
    end
    idle();

    // Scan order and frame period.
    run_until(0);
    fd_cnt = 0; fd_first = -1; fd_second = -1;
    for (int c = 1; c <= 2 * FRAME; c++) begin
      cycle();
      if (c < FRAME && (c % RD) == 5) begin
        chk("scan_data", 32'(digit_data), 32'(scan_vals[c / RD]));
        chk("scan_en", 32'(digit_en), 32'(1 << (c / RD)));
      end
      if (frame_done) begin
        fd_cnt++;
        if (fd_first < 0) fd_first = c; else fd_second = c;
      end
    end
    chk("fd_count", 32'(fd_cnt), 32'd2);
    chk("fd_period", 32'(fd_second - fd_first), 32'(FRAME));

    // Tear-free commit mid-frame.
    run_until(10);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'h9; commit = 1'b1;
    cycle();
    idle();
    chk("tear_pend_set", 32'(commit_pend), 32'd1);
    run_until(20);
    chk("tear_old_data", 32'(digit_data), 32'h3);
    chk("tear_old_en", 32'(digit_en), 32'h4);
    run_until(31);
    chk("tear_pend_hold", 32'(commit_pend), 32'd1);
    cycle();
    chk("tear_pend_clr", 32'(commit_pend), 32'd0);
    run_until(20);
    chk("tear_new_data", 32'(digit_data), 32'h9);

    // Commit and write in the frame_done cycle.
    run_until(31);
    chk("coll_fd", 32'(frame_done), 32'd1);
    commit = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'hA;
    cycle();
    idle();
    chk("coll_pend", 32'(commit_pend), 32'd0);
    run_until(10);
    chk("coll_data", 32'(digit_data), 32'hA);

    // Leading-zero suppression.
    lz_frame(16'h0005, 4'b0001);
    lz_frame(16'h0700, 4'b0111);
    lz_frame(16'h0000, 4'b0001);
    lz = 1'b0;

    // Disable mid-slot, commit while stopped, re-enable.
    run_until(19);
    en = 1'b0;
    write(3'd0, 4'h8);
    chk("off_en", 32'(digit_en), 32'd0);
    chk("off_fd", 32'(frame_done), 32'd0);
    chk("off_data_idx0", 32'(digit_data), 32'h0);
    commit = 1'b1;
    cycle();
    idle();
    chk("off_commit_data", 32'(digit_data), 32'h8);
    chk("off_commit_pend", 32'(commit_pend), 32'd0);
    en = 1'b1;
    cycle();
    chk("reen_dark1", 32'(digit_en), 32'd0);
    cycle();
    chk("reen_lit", 32'(digit_en), 32'h1);

    // Async reset during SHOW with a commit pending.
    run_until(3);
    commit = 1'b1;
    cycle();
    idle();
    chk("ar_pend_before", 32'(commit_pend), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_en", 32'(digit_en), 32'd0);
    chk("ar_data", 32'(digit_data), 32'd0);
    chk("ar_fd", 32'(frame_done), 32'd0);
    chk("ar_pend", 32'(commit_pend), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_until(0);
    for (int c = 0; c < FRAME; c++) cycle();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      en      = ($urandom_range(0, 19) != 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 4'($urandom_range(0, 15));
      commit  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) lz = ~lz;
      cycle();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
